// File: rtl/spi_regfile.sv
// spi_regfile: SPI mode-0 peripheral register file.
//   The frame is sent MSB first and sampled on SCLK rising edges:
//   R/W bit (1 = write), then ADDR_W address bits, then DATA_W data bits.
//   A write commits when nCS rises after a complete frame. A read loads
//   reg[addr] once the address is complete and shifts it out on CIPO on
//   SCLK falling edges.
// Ports:
//   clk, rst         system clock, synchronous active-high reset
//   sclk, copi, ncs  asynchronous SPI pins, each through a 2-FF synchroniser
//   cipo, cipo_oe    SPI read data and its output enable
//   reg_out          flat register bus, reg k at [k*DATA_W +: DATA_W]
//   wr_strobe        one-cycle pulse on a register commit
//   wr_addr          address of the last commit
//   rd_strobe        one-cycle pulse when read data is loaded
//   frame_err        one-cycle pulse when a frame is cut short
module spi_regfile #(
    parameter int                DATA_W      = 8,
    parameter int                ADDR_W      = 7,
    parameter int                NUM_REGS    = 5,
    parameter logic [DATA_W-1:0] RESET_VALUE = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         sclk,
    input  logic                         copi,
    input  logic                         ncs,
    output logic                         cipo,
    output logic                         cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0]   reg_out,
    output logic                         wr_strobe,
    output logic [ADDR_W-1:0]            wr_addr,
    output logic                         rd_strobe,
    output logic                         frame_err
);

    localparam int FRAME_LEN = 1 + ADDR_W + DATA_W;
    localparam int CNT_W     = $clog2(FRAME_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_ADDR_DONE = CNT_W'(1 + ADDR_W);
    localparam logic [CNT_W-1:0] CNT_SHIFT_MIN = CNT_W'(2 + ADDR_W);
    localparam logic [CNT_W-1:0] CNT_FRAME     = CNT_W'(FRAME_LEN);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DONE} state_t;

    // Synchronisers are deliberately left out of reset. They keep tracking
    // the pins, so a reset taken while nCS is low does not see a false edge.
    logic [2:0] sclk_sync_q;
    logic [2:0] ncs_sync_q;
    logic [1:0] copi_sync_q;

    always_ff @(posedge clk) begin
        sclk_sync_q <= {sclk_sync_q[1:0], sclk};
        ncs_sync_q  <= {ncs_sync_q[1:0], ncs};
        copi_sync_q <= {copi_sync_q[0], copi};
    end

    logic sclk_rise, sclk_fall, ncs_rise, ncs_fall, copi_s;
    assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
    assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
    assign ncs_rise  = ncs_sync_q[1] & ~ncs_sync_q[2];
    assign ncs_fall  = ~ncs_sync_q[1] & ncs_sync_q[2];
    assign copi_s    = copi_sync_q[1];

    state_t                             state_q;
    logic [CNT_W-1:0]                   cnt_q;
    logic                               rw_q;
    logic [ADDR_W-1:0]                  addr_q;
    logic [DATA_W-1:0]                  data_q;
    logic [DATA_W-1:0]                  out_sh_q;
    logic [NUM_REGS-1:0][DATA_W-1:0]    regs_q;
    logic                               cipo_q, cipo_oe_q;
    logic                               wr_strobe_q, rd_strobe_q, frame_err_q;
    logic [ADDR_W-1:0]                  wr_addr_q;

    // Next values of the shift registers. Widening by one bit first keeps
    // the slicing valid when ADDR_W or DATA_W is 1.
    logic [ADDR_W:0]   addr_ext;
    logic [DATA_W:0]   data_ext;
    logic [DATA_W:0]   out_ext;
    logic [CNT_W-1:0]  cnt_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] data_d;
    logic [DATA_W-1:0] out_sh_d;
    logic [DATA_W-1:0] rd_val;
    logic              wr_hit;

    always_comb begin
        cnt_d    = cnt_q + CNT_W'(1);
        addr_ext = {addr_q, copi_s};
        data_ext = {data_q, copi_s};
        out_ext  = {out_sh_q, 1'b0};
        addr_d   = addr_ext[ADDR_W-1:0];
        data_d   = data_ext[DATA_W-1:0];
        out_sh_d = out_ext[DATA_W-1:0];
        rd_val   = '0;
        wr_hit   = 1'b0;
        // Unimplemented addresses read 0 and never hit a write.
        for (int k = 0; k < NUM_REGS; k++) begin
            if (addr_d == ADDR_W'(k)) rd_val = regs_q[k];
            if (addr_q == ADDR_W'(k)) wr_hit = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            rw_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            out_sh_q    <= '0;
            regs_q      <= {NUM_REGS{RESET_VALUE}};
            cipo_q      <= 1'b0;
            cipo_oe_q   <= 1'b0;
            wr_strobe_q <= 1'b0;
            rd_strobe_q <= 1'b0;
            frame_err_q <= 1'b0;
            wr_addr_q   <= '0;
        end else begin
            wr_strobe_q <= 1'b0;
            rd_strobe_q <= 1'b0;
            frame_err_q <= 1'b0;
            if (ncs_fall) begin
                state_q   <= S_ADDR;
                cnt_q     <= '0;
                rw_q      <= 1'b0;
                addr_q    <= '0;
                data_q    <= '0;
                out_sh_q  <= '0;
                cipo_q    <= 1'b0;
                cipo_oe_q <= 1'b1;
            end else if (ncs_rise) begin
                // nCS rise takes priority over any SCLK edge in the same cycle.
                // A rise while IDLE is a glitch and is ignored.
                if (state_q == S_DONE) begin
                    if (rw_q && wr_hit) begin
                        for (int k = 0; k < NUM_REGS; k++)
                            if (addr_q == ADDR_W'(k)) regs_q[k] <= data_q;
                        wr_strobe_q <= 1'b1;
                        wr_addr_q   <= addr_q;
                    end
                end else if (state_q != S_IDLE) begin
                    frame_err_q <= 1'b1;
                end
                state_q   <= S_IDLE;
                cipo_q    <= 1'b0;
                cipo_oe_q <= 1'b0;
            end else if (state_q != S_IDLE) begin
                if (sclk_rise && cnt_q != CNT_FRAME) begin
                    // SCLK edges after a full frame are ignored.
                    cnt_q <= cnt_d;
                    if (cnt_q == '0)          rw_q   <= copi_s;
                    else if (state_q == S_ADDR) addr_q <= addr_d;
                    else                       data_q <= data_d;
                    if (cnt_d == CNT_ADDR_DONE) begin
                        state_q <= S_DATA;
                        if (!rw_q) begin
                            out_sh_q    <= rd_val;
                            cipo_q      <= rd_val[DATA_W-1];
                            rd_strobe_q <= 1'b1;
                        end
                    end
                    if (cnt_d == CNT_FRAME) state_q <= S_DONE;
                end else if (sclk_fall && !rw_q && cnt_q >= CNT_SHIFT_MIN) begin
                    // The fall right after the load does not shift: the
                    // controller has not yet sampled the MSB.
                    out_sh_q <= out_sh_d;
                    cipo_q   <= out_ext[DATA_W-1];
                end
            end
        end
    end

    assign reg_out   = regs_q;
    assign cipo      = cipo_q;
    assign cipo_oe   = cipo_oe_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;
    assign rd_strobe = rd_strobe_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_regfile.sv
module tb_spi_regfile;
    localparam int HALF = 6;  // SPI half period in clk cycles

    logic        clk, rst, sclk, copi, ncs;
    logic        cipo, cipo_oe, wr_strobe, rd_strobe, frame_err;
    logic [39:0] reg_out;
    logic [6:0]  wr_addr;

    spi_regfile #(.DATA_W(8), .ADDR_W(7), .NUM_REGS(5), .RESET_VALUE(8'hA5)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .copi(copi), .ncs(ncs),
        .cipo(cipo), .cipo_oe(cipo_oe), .reg_out(reg_out),
        .wr_strobe(wr_strobe), .wr_addr(wr_addr), .rd_strobe(rd_strobe),
        .frame_err(frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0, fails = 0;
    int wr_cnt = 0, rd_cnt = 0, fe_cnt = 0, both_cnt = 0;
    logic [6:0] last_wa = '0;
    logic [7:0] model [5];

    always @(negedge clk) begin
        if (wr_strobe) begin wr_cnt++; last_wa = wr_addr; end
        if (rd_strobe) rd_cnt++;
        if (frame_err) fe_cnt++;
        if (wr_strobe && frame_err) both_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [39:0] model_flat();
        logic [39:0] f;
        for (int k = 0; k < 5; k++) f[k*8 +: 8] = model[k];
        return f;
    endfunction

    // One transfer of nbits SCLK cycles. Bits beyond 16 are 1s.
    // rst_at >= 0 pulses rst before that bit is driven.
    task automatic xfer(input logic rw, input logic [6:0] a, input logic [7:0] d,
                        input int nbits, input int rst_at,
                        output logic [7:0] rd, output logic oe_mid);
        logic [19:0] fr;
        fr = {rw, a, d, 4'hF};
        rd = '0;
        ncs = 1'b0;
        wait_clk(HALF);
        oe_mid = cipo_oe;
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_at) begin rst = 1'b1; wait_clk(3); rst = 1'b0; end
            copi = fr[19-i];
            wait_clk(HALF);
            if (i >= 8 && i < 16) rd = {rd[6:0], cipo};
            sclk = 1'b1;
            wait_clk(HALF);
            sclk = 1'b0;
        end
        wait_clk(HALF);
        ncs = 1'b1;
        wait_clk(10);
    endtask

    // Full or short frame checked against the model's rules.
    task automatic frame_check(input string tag, input logic rw, input logic [6:0] a,
                               input logic [7:0] d, input int nbits);
        int w0, r0, f0;
        logic [7:0] rd, exp_rd;
        logic oe;
        bit full, hit;
        w0 = wr_cnt; r0 = rd_cnt; f0 = fe_cnt;
        full = (nbits >= 16);
        hit  = (a < 5);
        exp_rd = hit ? model[a] : 8'h00;
        xfer(rw, a, d, nbits, -1, rd, oe);
        if (rw && full && hit) model[a] = d;
        chk({tag, "_oe"}, oe, 1'b1);
        chk({tag, "_wr"}, wr_cnt - w0, (rw && full && hit) ? 1 : 0);
        chk({tag, "_rd"}, rd_cnt - r0, (!rw && nbits >= 8) ? 1 : 0);
        chk({tag, "_fe"}, fe_cnt - f0, full ? 0 : 1);
        if (rw && full && hit) chk({tag, "_wa"}, last_wa, a);
        if (!rw && full) chk({tag, "_rdata"}, rd, exp_rd);
        chk({tag, "_regs"}, reg_out, model_flat());
        chk({tag, "_oe_end"}, cipo_oe, 1'b0);
    endtask

    initial begin
        #2ms;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] rd;
        logic oe;
        int w0, f0;
        rst = 1'b1; sclk = 1'b0; copi = 1'b0; ncs = 1'b1;
        for (int k = 0; k < 5; k++) model[k] = 8'hA5;
        wait_clk(5);
        chk("rst_regs", reg_out, 40'hA5A5A5A5A5);
        chk("rst_oe", cipo_oe, 1'b0);
        chk("rst_cipo", cipo, 1'b0);
        chk("rst_strobes", {wr_strobe, rd_strobe, frame_err}, 3'b000);
        chk("rst_wa", wr_addr, 7'd0);
        rst = 1'b0;
        wait_clk(10);

        frame_check("wr2", 1'b1, 7'h02, 8'h3C, 16);
        frame_check("wr4", 1'b1, 7'h04, 8'h81, 16);
        frame_check("rd4", 1'b0, 7'h04, 8'h00, 16);
        frame_check("wr5", 1'b1, 7'h05, 8'h99, 16);
        frame_check("rd5", 1'b0, 7'h05, 8'h00, 16);
        frame_check("short1", 1'b1, 7'h01, 8'hFF, 12);
        frame_check("wr1", 1'b1, 7'h01, 8'h77, 16);
        frame_check("long0", 1'b1, 7'h00, 8'h5A, 20);
        chk("long0_val", reg_out[7:0], 8'h5A);

        // Reset during a transfer: no commit, no error, registers restored.
        w0 = wr_cnt; f0 = fe_cnt;
        xfer(1'b1, 7'h03, 8'h11, 16, 10, rd, oe);
        for (int k = 0; k < 5; k++) model[k] = 8'hA5;
        chk("midrst_wr", wr_cnt - w0, 0);
        chk("midrst_fe", fe_cnt - f0, 0);
        chk("midrst_regs", reg_out, 40'hA5A5A5A5A5);
        frame_check("post_rst_rd3", 1'b0, 7'h03, 8'h00, 16);

        for (int n = 0; n < 40; n++) begin
            logic rw;
            logic [6:0] a;
            logic [7:0] d;
            int nb;
            rw = 1'($urandom_range(0, 1));
            a  = 7'($urandom_range(0, 7));
            d  = 8'($urandom);
            nb = ($urandom_range(0, 1) == 1) ? 16 : int'($urandom_range(0, 20));
            frame_check("rand", rw, a, d, nb);
        end

        chk("exclusive", both_cnt, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
